pipe_exmem_stage: RTL and testbench

Parametrised EX/MEM pipeline stage register for the 16-bit core, generalised in data, register-address and control-field widths. It adds behaviour the current stage does not have:
- separate hold (freeze) and flush (bubble) controls
- an explicit valid bit
- per-flag masked flag update
- a sticky halt-seen latch
- a saturating bubble counter for performance debug

It sits between the ALU/EX stage and the data memory, and feeds the MEM/WB stage and the forwarding unit.

---
 rtl/cpu_pipe_pkg.sv | 28 ++
 rtl/pipe_field_reg.sv | 49 ++++
 rtl/pipe_exmem_stage.sv | 129 ++++++++++++
 tb/tb_pipe_exmem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the 16-bit core pipeline: bundle bit positions,
// flag positions and the default field widths.
package cpu_pipe_pkg;

    // Default field widths
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RADDR_W = 4;
    localparam int DEF_WB_W    = 4;
    localparam int DEF_MEM_W   = 2;
    localparam int DEF_FLAG_W  = 3;
    localparam int DEF_CNT_W   = 8;

    // WB bundle bit positions {RegWrite, MemtoReg, PCtoReg, Halt}
    localparam int WB_REGWRITE = 3;
    localparam int WB_MEMTOREG = 2;
    localparam int WB_PCTOREG  = 1;
    localparam int WB_HALT     = 0;

    // MEM bundle bit positions {MemWrite, MemRead}
    localparam int MEM_WRITE   = 1;
    localparam int MEM_READ    = 0;

    // Condition flag positions {Z, V, N}
    localparam int FLAG_Z      = 2;
    localparam int FLAG_V      = 1;
    localparam int FLAG_N      = 0;

endpackage

// File: rtl/pipe_field_reg.sv
// Pipeline field registers with async active-low reset.
// pipe_field_reg:    whole-field register with clear (priority) and hold.
// pipe_field_reg_en: per-bit write-enable register for architectural state
//                    that must survive bubbles and flushes.
module pipe_field_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear beats hold so a flush can squash a frozen stage.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

module pipe_field_reg_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Each bit takes d only where its enable is set; other bits keep their value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= (q & ~en) | (d & en);
        end
    end

endmodule

// File: rtl/pipe_exmem_stage.sv
// EX/MEM pipeline stage register. Priority per edge: flush > hold > load.
// A load with in_valid=0 is captured exactly like a flush (bubble), so
// control fields are zero whenever out_valid is zero. Flags, halt_seen and
// bubble_cnt are side state that bubbles never clear.
module pipe_exmem_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RADDR_W  = DEF_RADDR_W,
    parameter int WB_W     = DEF_WB_W,
    parameter int MEM_W    = DEF_MEM_W,
    parameter int FLAG_W   = DEF_FLAG_W,
    parameter int HALT_BIT = WB_HALT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WB_W-1:0]    wb_in,
    input  logic [MEM_W-1:0]   mem_in,
    input  logic [FLAG_W-1:0]  flag_in,
    input  logic [FLAG_W-1:0]  flag_we,
    input  logic [DATA_W-1:0]  alu_in,
    input  logic [DATA_W-1:0]  store_in,
    input  logic [RADDR_W-1:0] dst_in,
    input  logic [RADDR_W-1:0] src2_in,
    input  logic [DATA_W-1:0]  pc_in,
    output logic               out_valid,
    output logic [WB_W-1:0]    wb_out,
    output logic               mem_write,
    output logic               mem_read,
    output logic [FLAG_W-1:0]  flags_out,
    output logic [DATA_W-1:0]  alu_out,
    output logic [DATA_W-1:0]  store_out,
    output logic [RADDR_W-1:0] dst_out,
    output logic [RADDR_W-1:0] src2_out,
    output logic [DATA_W-1:0]  pc_out,
    output logic               halt_seen,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic               capture_bubble;
    logic               do_load;
    logic [MEM_W-1:0]   mem_q;
    logic [FLAG_W-1:0]  flag_en;

    // Decode this edge's action from flush/hold/in_valid.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        capture_bubble = 1'b0;
        do_load        = 1'b0;
        if (flush) begin
            capture_bubble = 1'b1;
        end else if (!hold) begin
            capture_bubble = !in_valid;
            do_load        = in_valid;
        end
    end

    assign flag_en = flag_we & {FLAG_W{do_load}};

    pipe_field_reg #(.WIDTH(1)) u_valid (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(1'b1), .q(out_valid)
    );

    pipe_field_reg #(.WIDTH(WB_W)) u_wb (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(wb_in), .q(wb_out)
    );

    pipe_field_reg #(.WIDTH(MEM_W)) u_mem (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(mem_in), .q(mem_q)
    );

    pipe_field_reg #(.WIDTH(DATA_W)) u_alu (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(alu_in), .q(alu_out)
    );

    pipe_field_reg #(.WIDTH(DATA_W)) u_store (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(store_in), .q(store_out)
    );

    pipe_field_reg #(.WIDTH(RADDR_W)) u_dst (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(dst_in), .q(dst_out)
    );

    pipe_field_reg #(.WIDTH(RADDR_W)) u_src2 (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(src2_in), .q(src2_out)
    );

    pipe_field_reg #(.WIDTH(DATA_W)) u_pc (
        .clk(clk), .rst(rst), .hold(hold), .clear(capture_bubble),
        .d(pc_in), .q(pc_out)
    );

    pipe_field_reg_en #(.WIDTH(FLAG_W)) u_flags (
        .clk(clk), .rst(rst), .en(flag_en), .d(flag_in), .q(flags_out)
    );

    assign mem_write = mem_q[MEM_WRITE];
    assign mem_read  = mem_q[MEM_READ];

    // Sticky halt: set by a loaded valid Halt, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_seen <= 1'b0;
        end else if (do_load && wb_in[HALT_BIT]) begin
            halt_seen <= 1'b1;
        end
    end

    // Saturating bubble counter; stops at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (capture_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_exmem_stage.sv
// Self-checking bench for pipe_exmem_stage (CNT_W=4 so saturation is reachable).
// A reference model predicts the post-edge outputs, pushes them into a
// scoreboard queue, and the DUT outputs are popped/compared after each edge.
module tb_pipe_exmem_stage;
    import cpu_pipe_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        logic        valid;
        logic [3:0]  wb;
        logic        mw;
        logic        mr;
        logic [2:0]  flags;
        logic [15:0] alu;
        logic [15:0] st;
        logic [3:0]  dst;
        logic [3:0]  src2;
        logic [15:0] pc;
        logic        halt;
        logic [CW-1:0] cnt;
    } out_t;

    logic          clk;
    logic          rst;
    logic          hold;
    logic          flush;
    logic          in_valid;
    logic [3:0]    wb_in;
    logic [1:0]    mem_in;
    logic [2:0]    flag_in;
    logic [2:0]    flag_we;
    logic [15:0]   alu_in;
    logic [15:0]   store_in;
    logic [3:0]    dst_in;
    logic [3:0]    src2_in;
    logic [15:0]   pc_in;
    logic          out_valid;
    logic [3:0]    wb_out;
    logic          mem_write;
    logic          mem_read;
    logic [2:0]    flags_out;
    logic [15:0]   alu_out;
    logic [15:0]   store_out;
    logic [3:0]    dst_out;
    logic [3:0]    src2_out;
    logic [15:0]   pc_out;
    logic          halt_seen;
    logic [CW-1:0] bubble_cnt;

    out_t model;
    out_t sb_q[$];
    int   n_vec;
    int   n_err;

    pipe_exmem_stage #(
        .DATA_W(16), .RADDR_W(4), .WB_W(4), .MEM_W(2),
        .FLAG_W(3), .HALT_BIT(WB_HALT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .in_valid(in_valid),
        .wb_in(wb_in), .mem_in(mem_in), .flag_in(flag_in), .flag_we(flag_we),
        .alu_in(alu_in), .store_in(store_in), .dst_in(dst_in), .src2_in(src2_in),
        .pc_in(pc_in), .out_valid(out_valid), .wb_out(wb_out),
        .mem_write(mem_write), .mem_read(mem_read), .flags_out(flags_out),
        .alu_out(alu_out), .store_out(store_out), .dst_out(dst_out),
        .src2_out(src2_out), .pc_out(pc_out), .halt_seen(halt_seen),
        .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t observed();
        out_t o;
        o = {out_valid, wb_out, mem_write, mem_read, flags_out, alu_out,
             store_out, dst_out, src2_out, pc_out, halt_seen, bubble_cnt};
        return o;
    endfunction

    // Reference behaviour: flush > hold > load; load with in_valid=0 is a bubble.
    function automatic out_t model_next(input out_t c);
        out_t n = c;
        if (flush || (!hold && !in_valid)) begin
            n.valid = 1'b0; n.wb = '0; n.mw = 1'b0; n.mr = 1'b0;
            n.alu = '0; n.st = '0; n.dst = '0; n.src2 = '0; n.pc = '0;
            if (c.cnt != {CW{1'b1}}) n.cnt = c.cnt + 1'b1;
        end else if (!hold) begin
            n.valid = 1'b1;
            n.wb    = wb_in;
            n.mw    = mem_in[MEM_WRITE];
            n.mr    = mem_in[MEM_READ];
            n.alu   = alu_in;
            n.st    = store_in;
            n.dst   = dst_in;
            n.src2  = src2_in;
            n.pc    = pc_in;
            for (int i = 0; i < 3; i++) if (flag_we[i]) n.flags[i] = flag_in[i];
            if (wb_in[WB_HALT]) n.halt = 1'b1;
        end
        return n;
    endfunction

    task automatic idle_inputs();
        hold = 0; flush = 0; in_valid = 0; wb_in = '0; mem_in = '0;
        flag_in = '0; flag_we = '0; alu_in = '0; store_in = '0;
        dst_in = '0; src2_in = '0; pc_in = '0;
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic tick();
        out_t exp;
        out_t got;
        model = model_next(model);
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        got = observed();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, exp);
        end
    endtask

    // Drop reset while the clock is low and confirm outputs clear without an edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (observed() !== '0) begin
            n_err++;
            $display("FAIL %s_async_clear got=%h exp=0", tag, observed());
        end
        n_vec++;
        if (halt_seen !== 1'b0 || bubble_cnt !== '0) begin
            n_err++;
            $display("FAIL %s_side_state got halt=%b cnt=%h exp halt=0 cnt=0", tag, halt_seen, bubble_cnt);
        end
        #3;
        rst = 1'b1;
        model = '0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        n_vec++;
        if (observed() !== '0) begin
            n_err++;
            $display("FAIL reset_initial got=%h exp=0", observed());
        end
        @(negedge clk);
        rst = 1'b1;
        model = '0;
        // Mid-stream reset after a loaded halting instruction.
        in_valid = 1; alu_in = 16'h1234; wb_in = 4'hF; mem_in = 2'b11;
        flag_in = 3'b111; flag_we = 3'b111;
        tick();
        n_vec++;
        if (alu_out !== 16'h1234 || halt_seen !== 1'b1) begin
            n_err++;
            $display("FAIL reset_preload got alu=%h halt=%b exp alu=1234 halt=1", alu_out, halt_seen);
        end
        idle_inputs();
        tick();
        pulse_reset("reset_mid");
    endtask

    task automatic test_load_hold();
        logic [CW-1:0] cnt0;
        idle_inputs();
        in_valid = 1; alu_in = 16'hBEEF; dst_in = 4'h5; store_in = 16'h0A0A;
        src2_in = 4'h3; pc_in = 16'h0042; wb_in = 4'b1000; mem_in = 2'b01;
        tick();
        cnt0 = bubble_cnt;
        hold = 1; alu_in = 16'h0000; dst_in = 4'h0; in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (alu_out !== 16'hBEEF || dst_out !== 4'h5 || out_valid !== 1'b1 || bubble_cnt !== cnt0) begin
                n_err++;
                $display("FAIL load_hold[%0d] got alu=%h dst=%h v=%b cnt=%h exp alu=beef dst=5 v=1 cnt=%h",
                         i, alu_out, dst_out, out_valid, bubble_cnt, cnt0);
            end
        end
    endtask

    task automatic test_flush_beats_hold();
        logic [CW-1:0] cnt0;
        cnt0 = bubble_cnt;
        idle_inputs();
        hold = 1; flush = 1; in_valid = 1; mem_in = 2'b10; wb_in = 4'hF; alu_in = 16'h5555;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || mem_write !== 1'b0 || wb_out !== 4'h0 || alu_out !== 16'h0
            || bubble_cnt !== cnt0 + 1'b1) begin
            n_err++;
            $display("FAIL flush_beats_hold got v=%b mw=%b wb=%h alu=%h cnt=%h exp v=0 mw=0 wb=0 alu=0 cnt=%h",
                     out_valid, mem_write, wb_out, alu_out, bubble_cnt, cnt0 + 1'b1);
        end
    endtask

    task automatic test_flags();
        pulse_reset("flags_rst");
        idle_inputs();
        n_vec++;
        if (flags_out !== 3'b000) begin
            n_err++;
            $display("FAIL flags_start got=%b exp=000", flags_out);
        end
        in_valid = 1; flag_in = 3'b111; flag_we = 3'b100;
        tick();
        n_vec++;
        if (flags_out !== 3'b100) begin
            n_err++;
            $display("FAIL flags_masked got=%b exp=100", flags_out);
        end
        flush = 1; flag_we = 3'b111;
        tick();
        flush = 0; hold = 1;
        tick();
        hold = 0; in_valid = 0;
        tick();
        n_vec++;
        if (flags_out !== 3'b100) begin
            n_err++;
            $display("FAIL flags_sticky got=%b exp=100", flags_out);
        end
        in_valid = 1; flag_in = 3'b010; flag_we = 3'b011;
        tick();
        n_vec++;
        if (flags_out !== 3'b110) begin
            n_err++;
            $display("FAIL flags_partial got=%b exp=110", flags_out);
        end
    endtask

    task automatic test_halt();
        idle_inputs();
        in_valid = 1; wb_in = 4'b0001;
        tick();
        wb_in = 4'b0000; flush = 1;
        tick();
        flush = 0;
        for (int i = 0; i < 10; i++) begin
            alu_in = 16'(i * 3);
            tick();
        end
        n_vec++;
        if (halt_seen !== 1'b1) begin
            n_err++;
            $display("FAIL halt_sticky got=%b exp=1", halt_seen);
        end
    endtask

    task automatic test_saturation();
        pulse_reset("sat_rst");
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (bubble_cnt !== CW'((i + 1 > 15) ? 15 : i + 1)) begin
                n_err++;
                $display("FAIL saturate[%0d] got=%h exp=%h", i, bubble_cnt, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        hold = 1; flush = 1;
        tick();
        n_vec++;
        if (bubble_cnt !== 4'hF) begin
            n_err++;
            $display("FAIL saturate_flush got=%h exp=f", bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset("b2b_rst");
        for (int i = 0; i < 60; i++) begin
            hold     = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 5) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            wb_in    = 4'($urandom) & 4'b1110;
            mem_in   = 2'($urandom);
            flag_in  = 3'($urandom);
            flag_we  = 3'($urandom);
            alu_in   = 16'($urandom);
            store_in = 16'($urandom);
            dst_in   = 4'($urandom);
            src2_in  = 4'($urandom);
            pc_in    = 16'($urandom);
            tick();
            n_vec++;
            if (!out_valid && (wb_out !== '0 || mem_write || mem_read)) begin
                n_err++;
                $display("FAIL bubble_ctrl[%0d] got wb=%h mw=%b mr=%b exp all 0", i, wb_out, mem_write, mem_read);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model = '0;
        test_reset();
        test_load_hold();
        test_flush_beats_hold();
        test_flags();
        test_halt();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
